// File: rtl/vote_button_qualifier.sv
// -----------------------------------------------------------------------------
// vote_button_qualifier
//
// Front end for the voting machine. The four raw candidate buttons are
// synchronized into the clk domain. A vote is qualified only after exactly one
// button has been held alone for HOLD_CYCLES consecutive clocks. Pressing more
// than one button rejects the attempt. After a vote, reject or abort, the block
// waits for every button to be released before it will qualify again.
//
// Parameters:
//   HOLD_CYCLES  required hold length in clocks (>= 2)
//   CNT_W        hold counter width, 2**CNT_W > HOLD_CYCLES
//
// Ports:
//   clk            system clock
//   rst            synchronous, active-high reset
//   mode           0 = voting, 1 = result view (already synchronous)
//   button1..4     raw asynchronous candidate buttons
//   vote_pulse     one-hot, single-cycle qualified vote (bit 0 = button1)
//   reject_pulse   single-cycle flag for a rejected multi-press
//   btn_sync       synchronized button levels, valid in both modes
//   busy           high while in QUALIFY or WAIT_RELEASE
//
// Handshake: vote_pulse and reject_pulse are fire-and-forget strobes. Each is
// valid for exactly one clock, there is no ready, and at most one of them is
// high in any cycle.
//
// The FSM state is held in the enum signal `state` so that checkers can bind to
// it by hierarchical name.
// -----------------------------------------------------------------------------
module vote_button_qualifier #(
  parameter int HOLD_CYCLES = 100_000_000,
  parameter int CNT_W       = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode,
  input  logic       button1,
  input  logic       button2,
  input  logic       button3,
  input  logic       button4,
  output logic [3:0] vote_pulse,
  output logic       reject_pulse,
  output logic [3:0] btn_sync,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    QUALIFY      = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t           state;
  logic [3:0]       sync1;
  logic [1:0]       sel;
  logic [CNT_W-1:0] cnt;

  logic [3:0] raw_btn;
  logic [3:0] sel_mask;
  logic       one_pressed;
  logic       any_pressed;
  logic       other_pressed;
  logic [1:0] press_idx;

  assign raw_btn = {button4, button3, button2, button1};

  // Clearing the lowest set bit leaves zero exactly when a single bit is set.
  assign any_pressed   = |btn_sync;
  assign one_pressed   = any_pressed && ((btn_sync & (btn_sync - 4'd1)) == 4'd0);
  assign sel_mask      = 4'b0001 << sel;
  assign other_pressed = |(btn_sync & ~sel_mask);

  // Index of the pressed button; only used when exactly one bit is set.
  always_comb begin
    press_idx = 2'd0;
    unique case (btn_sync)
      4'b0010: press_idx = 2'd1;
      4'b0100: press_idx = 2'd2;
      4'b1000: press_idx = 2'd3;
      default: press_idx = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1        <= 4'd0;
      btn_sync     <= 4'd0;
      state        <= IDLE;
      sel          <= 2'd0;
      cnt          <= '0;
      vote_pulse   <= 4'd0;
      reject_pulse <= 1'b0;
      busy         <= 1'b0;
    end else begin
      sync1        <= raw_btn;
      btn_sync     <= sync1;
      vote_pulse   <= 4'd0;
      reject_pulse <= 1'b0;

      case (state)
        IDLE: begin
          if (!mode) begin
            if (one_pressed) begin
              state <= QUALIFY;
              sel   <= press_idx;
              cnt   <= CNT_W'(1);
              busy  <= 1'b1;
            end else if (any_pressed) begin
              reject_pulse <= 1'b1;
              state        <= WAIT_RELEASE;
              busy         <= 1'b1;
            end
          end
        end

        QUALIFY: begin
          // Abort beats reject beats release beats terminal count.
          if (mode) begin
            state <= WAIT_RELEASE;
          end else if (other_pressed) begin
            reject_pulse <= 1'b1;
            state        <= WAIT_RELEASE;
          end else if (!btn_sync[sel]) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            vote_pulse <= sel_mask;
            state      <= WAIT_RELEASE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        WAIT_RELEASE: begin
          if (!any_pressed) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vote_button_qualifier.sv
module tb_vote_button_qualifier;

  localparam int HOLD = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       mode;
  logic [3:0] btn;
  logic [3:0] vote_pulse;
  logic       reject_pulse;
  logic [3:0] btn_sync;
  logic       busy;

  vote_button_qualifier #(.HOLD_CYCLES(HOLD), .CNT_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .mode         (mode),
    .button1      (btn[0]),
    .button2      (btn[1]),
    .button3      (btn[2]),
    .button4      (btn[3]),
    .vote_pulse   (vote_pulse),
    .reject_pulse (reject_pulse),
    .btn_sync     (btn_sync),
    .busy         (busy)
  );

  // ---------------- scoreboard ----------------
  // entry = {vote[3:0], reject, busy, btn_sync[3:0]}
  logic [9:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [3:0] m_s1 = 4'd0, m_s2 = 4'd0, m_vote = 4'd0;
  logic       m_rej = 1'b0;
  int         m_st = 0;  // 0 idle, 1 qualify, 2 wait release
  int         m_sel = 0;
  int         m_cnt = 0;

  task automatic model_step();
    logic [3:0] seen;
    seen = m_s2;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; m_st = 0; m_sel = 0; m_cnt = 0; m_vote = 0; m_rej = 0;
    end else begin
      m_vote = 0;
      m_rej  = 0;
      case (m_st)
        0: if (!mode) begin
             if ($countones(seen) == 1) begin
               for (int i = 0; i < 4; i++) if (seen[i]) m_sel = i;
               m_st = 1; m_cnt = 1;
             end else if ($countones(seen) >= 2) begin
               m_rej = 1; m_st = 2;
             end
           end
        1: begin
             if (mode) m_st = 2;
             else if ((seen & ~(4'b0001 << m_sel)) != 0) begin m_rej = 1; m_st = 2; end
             else if (!seen[m_sel]) begin m_st = 0; m_cnt = 0; end
             else if (m_cnt == HOLD - 1) begin m_vote = 4'b0001 << m_sel; m_st = 2; end
             else m_cnt++;
           end
        default: if (seen == 0) begin m_st = 0; m_cnt = 0; end
      endcase
      m_s2 = m_s1;
      m_s1 = btn;
    end
    exp_q.push_back({m_vote, m_rej, (m_st != 0), m_s2});
  endtask

  // ---------------- monitor counters ----------------
  int vote_n, rej_n, busy_n, first_vote_edge, edge_i;
  logic [3:0] last_vote;

  task automatic clear_mon();
    vote_n = 0; rej_n = 0; busy_n = 0; first_vote_edge = -1; edge_i = 0; last_vote = 0;
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    logic [9:0] e;
    model_step();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("vote_pulse",   {28'd0, vote_pulse}, {28'd0, e[9:6]});
    check("reject_pulse", {31'd0, reject_pulse}, {31'd0, e[5]});
    check("busy",         {31'd0, busy}, {31'd0, e[4]});
    check("btn_sync",     {28'd0, btn_sync}, {28'd0, e[3:0]});
    if (vote_pulse != 0) begin
      vote_n++;
      last_vote = vote_pulse;
      if (first_vote_edge < 0) first_vote_edge = edge_i;
    end
    if (reject_pulse) rej_n++;
    if (busy) busy_n++;
    edge_i++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; mode = 1'b0; btn = 4'd0;

    // reset hold with toggling buttons
    for (int i = 0; i < 10; i++) begin
      btn = 4'($urandom_range(0, 15));
      tick();
    end
    check("rst_vote", {28'd0, vote_pulse}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sync", {28'd0, btn_sync}, 32'd0);
    rst = 1'b0;
    mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      btn = 4'($urandom_range(0, 15));
      tick();
    end
    btn = 4'd0; mode = 1'b0;
    run(4);

    // clean vote: button2 held 8 cycles
    clear_mon();
    btn = 4'b0010; run(8);
    btn = 4'b0000; run(6);
    check("clean_count", vote_n, 1);
    check("clean_edge", first_vote_edge, HOLD + 1);
    check("clean_value", {28'd0, last_vote}, 32'b0010);
    check("clean_idle", {31'd0, busy}, 32'd0);

    // short press then a valid press
    clear_mon();
    btn = 4'b0001; run(HOLD - 1);
    btn = 4'b0000; run(6);
    check("short_count", vote_n, 0);
    check("short_busy", {31'd0, busy}, 32'd0);
    clear_mon();
    btn = 4'b0001; run(6);
    btn = 4'b0000; run(6);
    check("press6_count", vote_n, 1);
    check("press6_value", {28'd0, last_vote}, 32'b0001);

    // multi-press
    clear_mon();
    btn = 4'b0101; run(4);
    btn = 4'b0100; run(4);
    check("multi_busy_hold", {31'd0, busy}, 32'd1);
    btn = 4'b0000; run(5);
    check("multi_busy_end", {31'd0, busy}, 32'd0);
    check("multi_rej", rej_n, 1);
    check("multi_vote", vote_n, 0);

    // late second button, meeting the terminal count edge
    clear_mon();
    btn = 4'b1000; run(3);
    btn = 4'b1010; run(4);
    btn = 4'b0000; run(6);
    check("late_rej", rej_n, 1);
    check("late_vote", vote_n, 0);

    // mode abort mid-hold
    clear_mon();
    btn = 4'b0001; run(3);
    mode = 1'b1; run(5);
    btn = 4'b0000; run(5);
    mode = 1'b0;
    check("abort_vote", vote_n, 0);
    check("abort_busy_seen", {31'd0, busy_n > 0}, 32'd1);

    // mode on the terminal count edge
    clear_mon();
    btn = 4'b0001; run(HOLD + 1);
    mode = 1'b1; run(1);
    mode = 1'b0; run(3);
    btn = 4'b0000; run(6);
    check("term_mode_vote", vote_n, 0);

    // result view: presses never make the block busy
    clear_mon();
    mode = 1'b1;
    btn = 4'b0100; run(6);
    btn = 4'b1001; run(4);
    btn = 4'b0000; run(4);
    mode = 1'b0;
    check("view_busy", busy_n, 0);
    check("view_rej", rej_n, 0);
    check("view_vote", vote_n, 0);

    // reset mid-hold, button kept held afterwards
    clear_mon();
    btn = 4'b0001; run(3);
    rst = 1'b1; run(1);
    rst = 1'b0;
    clear_mon();
    run(8);
    btn = 4'b0000; run(6);
    check("rst_mid_count", vote_n, 1);
    check("rst_mid_edge", first_vote_edge, HOLD + 1);

    // random segments
    for (int s = 0; s < 80; s++) begin
      case ($urandom_range(0, 3))
        0: btn = 4'd0;
        1: btn = 4'($urandom_range(0, 15));
        default: btn = 4'b0001 << $urandom_range(0, 3);
      endcase
      mode = ($urandom_range(0, 7) == 0);
      rst  = ($urandom_range(0, 19) == 0);
      tick();
      rst = 1'b0;
      run($urandom_range(1, 8));
    end
    btn = 4'd0; mode = 1'b0;
    run(6);
    check("end_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
